// File: rtl/pulse_train_gen_pkg.sv
// Shared types and constants for the pulse train generator and its divider.
package pulse_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   localparam int CNT_W_DEF   = 28;
   localparam int BURST_W_DEF = 4;
   localparam int SEC_50MHZ   = 50_000_000;

endpackage

// File: rtl/pulse_train_gen_if.sv
// Control/status bundle between the timing controller (master) and the pulse train generator (slave).
interface pulse_train_gen_if
   import pulse_pkg::*;
#(
   parameter int CNT_W   = CNT_W_DEF,
   parameter int BURST_W = BURST_W_DEF
);
   // start/stop are one-cycle requests sampled on posedge clk: start is taken only in IDLE,
   // stop only in RUN, and stop beats start when both land in RUN; no ready is returned.
   logic               enable;
   logic               start;
   logic               stop;
   logic [CNT_W-1:0]   period;
   logic [BURST_W-1:0] burst_len;
   logic               busy;
   logic               out_pulse;
   logic               done;
   logic [BURST_W-1:0] pulses_left;
   state_e             state_dbg;

   modport master (
      output enable, start, stop, period, burst_len,
      input  busy, out_pulse, done, pulses_left, state_dbg
   );

   modport slave (
      input  enable, start, stop, period, burst_len,
      output busy, out_pulse, done, pulses_left, state_dbg
   );
endinterface

// File: rtl/pulse_train_gen_rate_divider.sv
// Reloading down-counter: counts enabled ticks and flags when the current period has elapsed.
module rate_divider
   import pulse_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             tick_en,
   output logic             zero
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // load_val doubles as the reload value when the count wraps at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (tick_en) begin
         if (cnt_q == '0) begin
            cnt_d = load_val;
         end else begin
            cnt_d = cnt_q - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/pulse_train_gen.sv
// Pulse train generator: emits single-cycle pulses every per_q enabled clocks, continuously or as a burst.
module pulse_train_gen
   import pulse_pkg::*;
#(
   parameter int CNT_W   = CNT_W_DEF,
   parameter int BURST_W = BURST_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   pulse_train_gen_if.slave  bus
);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   per_q, per_d;
   logic [BURST_W-1:0] left_q, left_d;
   logic               cont_q, cont_d;
   logic               fin_q, fin_d;
   logic               busy_q, busy_d;
   logic               pulse_q, pulse_d;
   logic               done_q, done_d;

   logic               accept;
   logic               abort;
   logic               fire;
   logic               last;
   logic [CNT_W-1:0]   start_per;
   logic               dv_load;
   logic [CNT_W-1:0]   dv_load_val;
   logic               dv_tick;
   logic               dv_zero;

   rate_divider #(
      .CNT_W (CNT_W)
   ) u_div (
      .clk      (clk),
      .reset    (reset),
      .load     (dv_load),
      .load_val (dv_load_val),
      .tick_en  (dv_tick),
      .zero     (dv_zero)
   );

   always_comb begin
      start_per = (bus.period == '0) ? CNT_W'(1) : bus.period;
      accept    = (state_q == ST_IDLE) && bus.start;
      abort     = (state_q == ST_RUN) && bus.stop;
      dv_tick   = (state_q == ST_RUN) && bus.enable && !bus.stop;
      fire      = dv_tick && dv_zero;
      last      = fire && !cont_q && (left_q == BURST_W'(1));

      // Stop clears the divider so a later start always begins from a clean count.
      dv_load   = accept || abort;
      if (accept) begin
         dv_load_val = start_per - CNT_W'(1);
      end else if (abort) begin
         dv_load_val = '0;
      end else begin
         dv_load_val = per_q - CNT_W'(1);
      end
   end

   always_comb begin
      state_d = state_q;
      per_d   = per_q;
      left_d  = left_q;
      cont_d  = cont_q;
      fin_d   = 1'b0;
      pulse_d = fire;
      done_d  = fin_q;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_RUN;
               per_d   = start_per;
               left_d  = bus.burst_len;
               cont_d  = (bus.burst_len == '0);
            end
         end
         ST_RUN: begin
            if (abort) begin
               state_d = ST_IDLE;
               left_d  = '0;
            end else if (fire && !cont_q) begin
               left_d = left_q - BURST_W'(1);
               if (last) begin
                  state_d = ST_IDLE;
                  fin_d   = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // busy covers the final pulse cycle and falls together with done.
      busy_d = (state_d == ST_RUN) || last;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         per_q   <= '0;
         left_q  <= '0;
         cont_q  <= 1'b0;
         fin_q   <= 1'b0;
         busy_q  <= 1'b0;
         pulse_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         per_q   <= per_d;
         left_q  <= left_d;
         cont_q  <= cont_d;
         fin_q   <= fin_d;
         busy_q  <= busy_d;
         pulse_q <= pulse_d;
         done_q  <= done_d;
      end
   end

   assign bus.busy        = busy_q;
   assign bus.out_pulse   = pulse_q;
   assign bus.done        = done_q;
   assign bus.pulses_left = left_q;
   assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Scoreboard bench: a behavioural model predicts every cycle's outputs; a monitor compares them.
module tb_pulse_train_gen;
   import pulse_pkg::*;

   localparam int CW = 28;
   localparam int BW = 4;
   localparam int EW = BW + 3;

   logic clk;
   logic reset;

   pulse_train_gen_if #(.CNT_W(CW), .BURST_W(BW)) bus ();

   pulse_train_gen #(.CNT_W(CW), .BURST_W(BW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [EW-1:0] exp_q[$];
   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Model: a train counts enabled clocks since the last pulse and fires when that reaches the period.
   bit      m_run;
   int      m_per;
   int      m_left;
   bit      m_cont;
   int      m_since;
   bit      m_fin;

   task automatic model_edge(input bit rst, input bit en, input bit st, input bit sp,
                             input int per, input int bl);
      bit pulse;
      bit done;
      pulse = 0;
      done  = 0;
      if (rst) begin
         m_run = 0; m_per = 0; m_left = 0; m_cont = 0; m_since = 0; m_fin = 0;
      end else begin
         done  = m_fin;
         m_fin = 0;
         if (!m_run) begin
            if (st) begin
               m_run   = 1;
               m_per   = (per == 0) ? 1 : per;
               m_left  = bl;
               m_cont  = (bl == 0);
               m_since = 0;
            end
         end else if (sp) begin
            m_run  = 0;
            m_left = 0;
         end else if (en) begin
            m_since++;
            if (m_since == m_per) begin
               pulse   = 1;
               m_since = 0;
               if (!m_cont) begin
                  m_left--;
                  if (m_left == 0) begin
                     m_run = 0;
                     m_fin = 1;
                  end
               end
            end
         end
      end
      exp_q.push_back({(m_run | m_fin), pulse, done, BW'(m_left)});
   endtask

   task automatic step(input bit rst, input bit en, input bit st, input bit sp,
                       input int per, input int bl);
      @(negedge clk);
      reset         = rst;
      bus.enable    = en;
      bus.start     = st;
      bus.stop      = sp;
      bus.period    = CW'(per);
      bus.burst_len = BW'(bl);
      model_edge(rst, en, st, sp, per, bl);
   endtask

   task automatic idle(input int n, input bit en);
      for (int i = 0; i < n; i++) step(0, en, 0, 0, 0, 0);
   endtask

   // Monitor: every clock the DUT presents a full output vector, compared against the next expectation.
   initial begin
      logic [EW-1:0] exp;
      logic [EW-1:0] got;
      forever begin
         @(posedge clk);
         #2;
         cyc++;
         if (exp_q.size() != 0) begin
            exp = exp_q.pop_front();
            got = {bus.busy, bus.out_pulse, bus.done, bus.pulses_left};
            checks++;
            if (got !== exp) begin
               failures++;
               $display("FAIL outputs cycle %0d: got busy=%0b pulse=%0b done=%0b left=%0d, expected busy=%0b pulse=%0b done=%0b left=%0d",
                        cyc, got[EW-1], got[EW-2], got[EW-3], got[BW-1:0],
                        exp[EW-1], exp[EW-2], exp[EW-3], exp[BW-1:0]);
            end
         end
      end
   end

   initial begin
      reset = 1'b1; bus.enable = 1'b0; bus.start = 1'b0; bus.stop = 1'b0;
      bus.period = '0; bus.burst_len = '0;
      m_run = 0; m_per = 0; m_left = 0; m_cont = 0; m_since = 0; m_fin = 0;

      // Reset held with start asserted.
      for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 4, 3);
      idle(2, 1);

      // Burst of 3 at period 4, an ignored mid-train start, then a start on the done cycle.
      step(0, 1, 1, 0, 4, 3);
      for (int i = 1; i <= 13; i++) step(0, 1, (i == 6), 0, 9, 5);
      step(0, 1, 1, 0, 2, 2);
      idle(8, 1);

      // Continuous at period 1, then stop.
      step(0, 1, 1, 0, 1, 0);
      idle(6, 1);
      step(0, 1, 0, 1, 0, 0);
      idle(4, 1);

      // Pause after two enabled cycles.
      step(0, 1, 1, 0, 5, 2);
      idle(2, 1);
      idle(7, 0);
      idle(12, 1);

      // Period 0 treated as 1.
      step(0, 1, 1, 0, 0, 1);
      idle(4, 1);

      // Random traffic including start/stop collisions and occasional resets.
      for (int i = 0; i < 1500; i++) begin
         step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0),
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 99) < 4),
              int'($urandom_range(0, 6)), int'($urandom_range(0, 4)));
      end
      idle(3, 1);

      @(posedge clk);
      #3;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard drain: got %0d pending, expected 0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
